gelato_l1_icache: RTL and testbench
===================================

Name: gelato_l1_icache

Overview:
- Direct-mapped, read-only L1 instruction cache. It is the responder side of the I-Fetch request interface.
- Accepts one word-aligned fetch address at a time and returns the 32-bit instruction word.
- On a miss, refills a whole line from the L2/memory port.
- Sits between the instruction-fetch unit and the shared memory interconnect.

Parameters:
ADDR_WIDTH, 32, byte address width.
DATA_WIDTH, 32, instruction word width; 32 is the only supported value.
LINE_WORDS, 4, words per line; must be a power of 2 and at least 2.
NUM_LINES, 64, number of lines; must be a power of 2.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
rdy  in  1  global enable; when 0, all state and outputs hold
req_valid  in  1  fetch request present
req_addr  in  ADDR_WIDTH  byte address; bits [1:0] are ignored
req_ready  out  1  request accepted this cycle (asserted only in IDLE)
resp_valid  out  1  one-cycle pulse; resp_data is valid
resp_data  out  DATA_WIDTH  instruction word
flush  in  1  invalidate all lines
mem_req_valid  out  1  line refill request
mem_req_addr  out  ADDR_WIDTH  line-aligned refill address
mem_req_ready  in  1  memory accepts the request
mem_resp_valid  in  1  one refill beat (one word), delivered in address order
mem_resp_data  in  DATA_WIDTH  refill word

Behaviour:
- Address split:
  - offset = addr[log2(LINE_WORDS)+1:2]
  - index = next log2(NUM_LINES) bits
  - tag = remaining upper bits
- Per-line storage: valid bit, tag, LINE_WORDS data words. Only the valid bits are reset.
- Reset, synchronous, while rst=1:
  - state = IDLE
  - all valid bits = 0
  - req_ready = 0, resp_valid = 0, mem_req_valid = 0
  - resp_data = 0, mem_req_addr = 0
- rdy=0: nothing changes, including reset-free state; outputs hold their values.
- IDLE:
  - req_ready=1 combinationally.
  - If req_valid=1: latch addr, go to LOOKUP.
- LOOKUP:
  - Hit (valid && tag match):
    - resp_valid=1 next cycle, resp_data = stored word.
    - Return to IDLE.
    - Hit latency: request accepted in cycle N, resp_valid in N+2.
  - Miss:
    - Set mem_req_valid=1 and mem_req_addr = latched addr with low log2(LINE_WORDS)+2 bits zeroed.
    - Go to REFILL_REQ.
- REFILL_REQ:
  - Hold mem_req_valid and mem_req_addr until mem_req_ready=1.
  - Then drop mem_req_valid, clear beat counter, go to REFILL_WAIT.
- REFILL_WAIT:
  - Each mem_resp_valid beat writes word[beat_cnt] and increments beat_cnt.
  - On the final beat (beat_cnt == LINE_WORDS-1):
    - Write tag, set valid.
    - Go to RESPOND.
  - Beats arriving in any other state are ignored.
- RESPOND:
  - resp_valid=1 for one cycle with the requested word; this uses the same data path as a hit.
  - Return to IDLE.
- resp_valid is a single-cycle pulse. The consumer must always be able to accept it; there is no backpressure.
- At most one outstanding request. req_ready=0 in every state except IDLE.
- flush:
  - In IDLE or LOOKUP: clears all valid bits in that cycle. A LOOKUP in the same cycle is treated as a miss.
  - During REFILL_REQ or REFILL_WAIT: the refill completes and responds. The refilled line is left invalid, and all others are cleared.
- beat_cnt wraps modulo LINE_WORDS and is cleared on entry to REFILL_WAIT.
- Illegal state encoding: return to IDLE with no outputs asserted.

Test Plan:
- Reset, then req 0x0000_0100: miss. mem_req_addr=0x100. Supply beats 0x11,0x22,0x33,0x44 → resp_valid once, resp_data=0x11.
- Then req 0x0000_0108 → hit, no mem_req_valid, resp_data=0x33 exactly 2 cycles after acceptance.
- Req 0x0000_0500 (same index as 0x100 with default params, different tag) → miss, refill replaces the line. A following req 0x100 → miss again.
- Hold mem_req_ready=0 for 5 cycles → mem_req_valid and mem_req_addr stable, req_ready=0 throughout.
- flush pulse after filling 0x100 → next req 0x104 misses. flush during REFILL_WAIT → response still delivered, line invalid afterwards.
- rdy=0 for 3 cycles mid-refill with beats withheld → state and outputs frozen. rst=1 mid-refill → IDLE and all lines invalid on the next cycle.

Source files
------------

// File: rtl/gelato_l1_icache.sv
// Direct-mapped, read-only L1 instruction cache; refills a whole line from L2 on a miss.
// Hit response two cycles after acceptance; one request outstanding, no response backpressure.
module gelato_l1_icache #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LINE_WORDS = 4,
   parameter int NUM_LINES  = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic                  req_valid,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   output logic                  req_ready,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_data,
   input  logic                  flush,
   output logic                  mem_req_valid,
   output logic [ADDR_WIDTH-1:0] mem_req_addr,
   input  logic                  mem_req_ready,
   input  logic                  mem_resp_valid,
   input  logic [DATA_WIDTH-1:0] mem_resp_data
);
   localparam int OFF_W   = $clog2(LINE_WORDS);
   localparam int IDX_W   = $clog2(NUM_LINES);
   localparam int TAG_LSB = OFF_W + IDX_W + 2;
   localparam int TAG_W   = ADDR_WIDTH - TAG_LSB;
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'((LINE_WORDS * 4) - 1);

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_LOOKUP      = 3'd1,
      S_REFILL_REQ  = 3'd2,
      S_REFILL_WAIT = 3'd3,
      S_RESPOND     = 3'd4
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [OFF_W-1:0]      beat_cnt_q, beat_cnt_d;
   logic                  flush_pend_q, flush_pend_d;
   logic [NUM_LINES-1:0]  valid_q, valid_d;
   logic                  resp_valid_q, resp_valid_d;
   logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
   logic                  mem_req_valid_q, mem_req_valid_d;
   logic [ADDR_WIDTH-1:0] mem_req_addr_q, mem_req_addr_d;

   // Tag and data arrays carry no reset; only the valid bits qualify them.
   logic [TAG_W-1:0]      tag_mem  [NUM_LINES];
   logic [DATA_WIDTH-1:0] data_mem [NUM_LINES*LINE_WORDS];

   logic                  data_we;
   logic                  tag_we;
   logic [OFF_W-1:0]      req_off;
   logic [IDX_W-1:0]      req_idx;
   logic [TAG_W-1:0]      req_tag;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  hit;

   assign req_off = addr_q[OFF_W+1:2];
   assign req_idx = addr_q[TAG_LSB-1:OFF_W+2];
   assign req_tag = addr_q[ADDR_WIDTH-1:TAG_LSB];
   assign rd_word = data_mem[{req_idx, req_off}];
   assign hit     = valid_q[req_idx] && (tag_mem[req_idx] == req_tag) && !flush;

   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      beat_cnt_d      = beat_cnt_q;
      flush_pend_d    = flush_pend_q;
      valid_d         = valid_q;
      resp_valid_d    = 1'b0;
      resp_data_d     = resp_data_q;
      mem_req_valid_d = mem_req_valid_q;
      mem_req_addr_d  = mem_req_addr_q;
      data_we         = 1'b0;
      tag_we          = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (hit) begin
               resp_valid_d = 1'b1;
               resp_data_d  = rd_word;
               state_d      = S_IDLE;
            end else begin
               mem_req_valid_d = 1'b1;
               mem_req_addr_d  = addr_q & ~LINE_MASK;
               flush_pend_d    = 1'b0;
               state_d         = S_REFILL_REQ;
            end
         end
         S_REFILL_REQ: begin
            if (mem_req_ready) begin
               mem_req_valid_d = 1'b0;
               beat_cnt_d      = '0;
               state_d         = S_REFILL_WAIT;
            end
         end
         S_REFILL_WAIT: begin
            if (mem_resp_valid) begin
               data_we    = 1'b1;
               beat_cnt_d = beat_cnt_q + OFF_W'(1);
               if (beat_cnt_q == OFF_W'(LINE_WORDS - 1)) begin
                  tag_we           = 1'b1;
                  valid_d[req_idx] = !flush_pend_q;
                  state_d          = S_RESPOND;
               end
            end
         end
         S_RESPOND: begin
            resp_valid_d = 1'b1;
            resp_data_d  = rd_word;
            state_d      = S_IDLE;
         end
         default: begin
            mem_req_valid_d = 1'b0;
            state_d         = S_IDLE;
         end
      endcase

      // A flush mid-refill still lets the refill finish, but the new line stays invalid.
      if (flush) begin
         valid_d = '0;
         if (state_q == S_REFILL_REQ || state_q == S_REFILL_WAIT) begin
            flush_pend_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_IDLE;
         addr_q          <= '0;
         beat_cnt_q      <= '0;
         flush_pend_q    <= 1'b0;
         valid_q         <= '0;
         resp_valid_q    <= 1'b0;
         resp_data_q     <= '0;
         mem_req_valid_q <= 1'b0;
         mem_req_addr_q  <= '0;
      end else if (rdy) begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         beat_cnt_q      <= beat_cnt_d;
         flush_pend_q    <= flush_pend_d;
         valid_q         <= valid_d;
         resp_valid_q    <= resp_valid_d;
         resp_data_q     <= resp_data_d;
         mem_req_valid_q <= mem_req_valid_d;
         mem_req_addr_q  <= mem_req_addr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && rdy) begin
         if (data_we) begin
            data_mem[{req_idx, beat_cnt_q}] <= mem_resp_data;
         end
         if (tag_we) begin
            tag_mem[req_idx] <= req_tag;
         end
      end
   end

   assign req_ready     = (state_q == S_IDLE) && !rst;
   assign resp_valid    = resp_valid_q;
   assign resp_data     = resp_data_q;
   assign mem_req_valid = mem_req_valid_q;
   assign mem_req_addr  = mem_req_addr_q;

endmodule

// File: tb/tb_gelato_l1_icache.sv
// Bench for gelato_l1_icache: vector table of fetches with a response scoreboard,
// plus hand sequences for flush, stall, rdy freeze and mid-refill reset.
module tb_gelato_l1_icache;

   typedef struct {
      logic [31:0] addr;
      bit          miss;
      logic [31:0] data;
      int          stall;
      bit          gap;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        flush;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_req_ready;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;

   int          n_vec = 0;
   int          n_mis = 0;
   logic [31:0] sb_q[$];
   vec_t        vecs[13];

   gelato_l1_icache #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .LINE_WORDS(4),
      .NUM_LINES (64)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rdy           (rdy),
      .req_valid     (req_valid),
      .req_addr      (req_addr),
      .req_ready     (req_ready),
      .resp_valid    (resp_valid),
      .resp_data     (resp_data),
      .flush         (flush),
      .mem_req_valid (mem_req_valid),
      .mem_req_addr  (mem_req_addr),
      .mem_req_ready (mem_req_ready),
      .mem_resp_valid(mem_resp_valid),
      .mem_resp_data (mem_resp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, want finish before time limit");
      $fatal(1);
   end

   // Backing-store image: line 0x100 holds the fixed words, everything else is address-derived.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] w;
      w = a & ~32'h3;
      case (w)
         32'h100: return 32'h11;
         32'h104: return 32'h22;
         32'h108: return 32'h33;
         32'h10C: return 32'h44;
         default: return w ^ 32'h5A5A_0000;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst === 1'b0 && resp_valid === 1'b1) begin
         if (sb_q.size() == 0) chk("resp_unexpected", 32'(resp_valid), 32'd0);
         else chk("resp_data", resp_data, sb_q.pop_front());
      end
   end

   task automatic accept(input logic [31:0] a, input logic [31:0] exp_d);
      int n;
      n = 0;
      req_valid = 1'b1;
      req_addr  = a;
      while (req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      if (req_ready === 1'b1) sb_q.push_back(exp_d);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic check_refill_req(input string nm, input logic [31:0] line);
      chk({nm, "_mem_req_valid"}, 32'(mem_req_valid), 32'd1);
      chk({nm, "_mem_req_addr"}, mem_req_addr, line);
      chk({nm, "_req_ready_busy"}, 32'(req_ready), 32'd0);
   endtask

   task automatic handshake(input string nm);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      chk({nm, "_mem_req_drop"}, 32'(mem_req_valid), 32'd0);
   endtask

   task automatic beats(input logic [31:0] line, input int first, input int cnt, input bit gap);
      for (int b = first; b < first + cnt; b++) begin
         if (gap) begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = 32'hBAD0_BAD0;
            @(negedge clk);
         end
         mem_resp_valid = 1'b1;
         mem_resp_data  = mem_word(line + 32'(4 * b));
         @(negedge clk);
      end
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'hBAD0_BAD0;
   endtask

   task automatic wait_resp(input string nm);
      int n;
      n = 0;
      while (resp_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_resp_seen"}, 32'(resp_valid), 32'd1);
      @(negedge clk);
      chk({nm, "_resp_pulse"}, 32'(resp_valid), 32'd0);
   endtask

   task automatic fetch(input vec_t v, input string nm);
      logic [31:0] line;
      line = v.addr & ~32'hF;
      accept(v.addr, v.data);
      @(negedge clk);
      if (v.miss) begin
         check_refill_req(nm, line);
         // Stray beats while the request is still pending must be ignored.
         for (int i = 0; i < v.stall; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'hDEAD_BEEF;
            @(negedge clk);
            check_refill_req({nm, "_stall"}, line);
         end
         mem_resp_valid = 1'b0;
         handshake(nm);
         beats(line, 0, 4, v.gap);
         wait_resp(nm);
      end else begin
         chk({nm, "_hit_latency"}, 32'(resp_valid), 32'd1);
         chk({nm, "_hit_no_mem"}, 32'(mem_req_valid), 32'd0);
         @(negedge clk);
         chk({nm, "_resp_pulse"}, 32'(resp_valid), 32'd0);
      end
   endtask

   initial begin
      vec_t hv;

      vecs[0]  = '{32'h0000_0100, 1'b1, 32'h11, 0, 1'b0};
      vecs[1]  = '{32'h0000_0108, 1'b0, 32'h33, 0, 1'b0};
      vecs[2]  = '{32'h0000_010C, 1'b0, 32'h44, 0, 1'b0};
      vecs[3]  = '{32'h0000_0500, 1'b1, mem_word(32'h500), 1, 1'b1};
      vecs[4]  = '{32'h0000_0504, 1'b0, mem_word(32'h504), 0, 1'b0};
      vecs[5]  = '{32'h0000_0100, 1'b1, 32'h11, 5, 1'b0};
      vecs[6]  = '{32'h0000_0103, 1'b0, 32'h11, 0, 1'b0};
      vecs[7]  = '{32'h0000_0200, 1'b1, mem_word(32'h200), 2, 1'b1};
      vecs[8]  = '{32'h0000_0104, 1'b0, 32'h22, 0, 1'b0};
      vecs[9]  = '{32'h0000_020C, 1'b0, mem_word(32'h20C), 0, 1'b0};
      vecs[10] = '{32'hFFFF_FFF0, 1'b1, mem_word(32'hFFFF_FFF0), 0, 1'b0};
      vecs[11] = '{32'hFFFF_FFFE, 1'b0, mem_word(32'hFFFF_FFFC), 0, 1'b0};
      vecs[12] = '{32'h0000_0000, 1'b1, mem_word(32'h0), 1, 1'b0};

      rst            = 1'b1;
      rdy            = 1'b1;
      req_valid      = 1'b0;
      req_addr       = 32'h0;
      flush          = 1'b0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_mem_req_addr", mem_req_addr, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_req_ready", 32'(req_ready), 32'd1);

      for (int i = 0; i < 13; i++) begin
         fetch(vecs[i], $sformatf("vec%0d", i));
      end

      // flush while idle drops every line
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      hv = '{32'h0000_0104, 1'b1, 32'h22, 0, 1'b0};
      fetch(hv, "flush_idle_a");
      hv = '{32'h0000_0208, 1'b1, mem_word(32'h208), 0, 1'b0};
      fetch(hv, "flush_idle_b");

      // flush during the lookup cycle turns a would-be hit into a miss
      accept(32'h0000_0108, 32'h33);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check_refill_req("flush_lookup", 32'h100);
      handshake("flush_lookup");
      beats(32'h100, 0, 4, 1'b0);
      wait_resp("flush_lookup");
      hv = '{32'h0000_010C, 1'b0, 32'h44, 0, 1'b0};
      fetch(hv, "flush_lookup_after");

      // flush during refill: response still arrives, line and all others invalid
      accept(32'h0000_0608, mem_word(32'h608));
      @(negedge clk);
      check_refill_req("flush_wait", 32'h600);
      handshake("flush_wait");
      beats(32'h600, 0, 2, 1'b0);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      beats(32'h600, 2, 2, 1'b0);
      wait_resp("flush_wait");
      hv = '{32'h0000_0600, 1'b1, mem_word(32'h600), 0, 1'b0};
      fetch(hv, "flush_wait_line");
      hv = '{32'h0000_0100, 1'b1, 32'h11, 0, 1'b0};
      fetch(hv, "flush_wait_other");

      // rdy low freezes the pending request even with mem_req_ready high, then mid-refill
      accept(32'h0000_0704, mem_word(32'h704));
      @(negedge clk);
      check_refill_req("rdy_req", 32'h700);
      rdy           = 1'b0;
      mem_req_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_refill_req("rdy_req_frozen", 32'h700);
      end
      rdy           = 1'b1;
      mem_req_ready = 1'b0;
      @(negedge clk);
      check_refill_req("rdy_req_resume", 32'h700);
      handshake("rdy_wait");
      beats(32'h700, 0, 2, 1'b0);
      rdy = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("rdy_wait_resp_valid", 32'(resp_valid), 32'd0);
         chk("rdy_wait_mem_req_valid", 32'(mem_req_valid), 32'd0);
         chk("rdy_wait_req_ready", 32'(req_ready), 32'd0);
      end
      rdy = 1'b1;
      beats(32'h700, 2, 2, 1'b0);
      wait_resp("rdy_wait");
      hv = '{32'h0000_070C, 1'b0, mem_word(32'h70C), 0, 1'b0};
      fetch(hv, "rdy_after_hit");

      // reset mid-refill abandons the request and invalidates all lines
      accept(32'h0000_0300, mem_word(32'h300));
      @(negedge clk);
      check_refill_req("rst_mid", 32'h300);
      handshake("rst_mid");
      beats(32'h300, 0, 2, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_req_ready", 32'(req_ready), 32'd0);
      chk("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_mid_mem_req_valid", 32'(mem_req_valid), 32'd0);
      chk("rst_mid_mem_req_addr", mem_req_addr, 32'd0);
      chk("rst_mid_resp_data", resp_data, 32'd0);
      rst = 1'b0;
      sb_q.delete();
      @(negedge clk);
      chk("rst_mid_idle", 32'(req_ready), 32'd1);
      hv = '{32'h0000_0100, 1'b1, 32'h11, 1, 1'b1};
      fetch(hv, "rst_mid_inval_a");
      hv = '{32'h0000_0704, 1'b1, mem_word(32'h704), 0, 1'b0};
      fetch(hv, "rst_mid_inval_b");

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
